// File: rtl/instr_link_pkg.sv
// Shared definitions for the instruction-register four-phase link:
// PH1 encodings, TX handshake states and default widths.
package instr_link_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_ADDR_W = 8;
  localparam int DEFAULT_DEPTH  = 4;

  localparam logic [1:0] PH1_VALID  = 2'b10;
  localparam logic [1:0] PH1_SPACER = 2'b00;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SETUP,
    TX_REQ,
    TX_RTZ
  } tx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for bringing an asynchronous level into
// the clk domain; output lags the input by two rising edges.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // their inputs from the same edge, giving a true two-stage delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/instr_fetch_tx.sv
// Prefetches instruction words into a small FIFO and issues them one at a
// time as four-phase (data, PH1) tokens towards instr_reg.
module instr_fetch_tx
  import instr_link_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        ph1_out,
  input  logic              ack_in,
  output logic              busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic              ack_s;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q;
  logic [DATA_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  credit_used;
  logic              fifo_empty;
  logic              rd_en, push, pop;
  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              flushed_q, flushed_d;

  sync_2ff u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d_i (ack_in),
    .q_o (ack_s)
  );

  // Credit counts the read still in flight so the FIFO can never overflow.
  assign credit_used = count_q + CNT_W'(inflight_q);
  assign fifo_empty  = (count_q == '0);
  assign rd_en       = !rst && run && !pc_load && (credit_used < CNT_W'(DEPTH));
  assign push        = inflight_q && !pc_load;
  assign pop         = (state_q == TX_REQ) && ack_s && !pc_load && !flushed_q;

  assign mem_rd_en = rd_en;
  assign mem_addr  = pc_q;

  always_comb begin
    pc_d = pc_q;
    if (pc_load)    pc_d = pc_load_val;
    else if (rd_en) pc_d = pc_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= rd_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || pc_load) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  // NOTE: the storage array has no reset; count_q alone says which entries
  // are valid, so clearing the data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= mem_rd_data;
  end

  // TX state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= TX_IDLE;
      data_q    <= '0;
      flushed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      flushed_q <= flushed_d;
    end
  end

  // TX next state. flushed_q remembers a redirect seen during REQ so the
  // eventual pop does not consume a word fetched from the new PC.
  // NOTE: every combinational output gets a default first, so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    flushed_d = flushed_q;
    case (state_q)
      TX_IDLE: begin
        if (!fifo_empty && !ack_s && !pc_load) begin
          state_d = TX_SETUP;
          data_d  = fifo_mem[rd_ptr_q];
        end
      end
      TX_SETUP: state_d = pc_load ? TX_IDLE : TX_REQ;
      TX_REQ: begin
        if (pc_load) flushed_d = 1'b1;
        if (ack_s) begin
          state_d   = TX_RTZ;
          flushed_d = 1'b0;
        end
      end
      TX_RTZ: begin
        if (!ack_s) state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // TX outputs
  always_comb begin
    ph1_out  = (state_q == TX_REQ) ? PH1_VALID : PH1_SPACER;
    data_out = ((state_q == TX_SETUP) || (state_q == TX_REQ)) ? data_q : '0;
    busy     = !fifo_empty || inflight_q || (state_q != TX_IDLE);
  end

endmodule

// File: tb/tb_instr_fetch_tx.sv
// Directed bench for instr_fetch_tx: memory model, configurable ack
// responder and a token monitor feeding per-scenario checking tasks.
module tb_instr_fetch_tx;

  logic        clk = 1'b0;
  logic        rst, run, pc_load;
  logic [7:0]  pc_load_val;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rd_data = '0;
  logic [15:0] data_out;
  logic [1:0]  ph1_out;
  logic        ack_in;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef enum int {ACK_LOW, ACK_ECHO, ACK_HIGH} ack_mode_e;
  ack_mode_e   ack_mode = ACK_LOW;
  logic [2:0]  ack_dly = '0;
  logic [15:0] mem [256];

  logic [15:0] tokens[$];
  logic [7:0]  addrs[$];
  int          illegal_ph1 = 0;
  int          data_glitch = 0;
  logic [1:0]  prev_ph1 = 2'b00;
  logic [15:0] prev_data = '0;

  always #5 clk = ~clk;

  instr_fetch_tx dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .data_out    (data_out),
    .ph1_out     (ph1_out),
    .ack_in      (ack_in),
    .busy        (busy)
  );

  // Memory with one-cycle read latency; receiver echoes ph1[1] after 3 clk.
  always @(posedge clk) begin
    ack_dly <= {ack_dly[1:0], ph1_out[1]};
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
  end

  assign ack_in = (ack_mode == ACK_HIGH) ? 1'b1 :
                  (ack_mode == ACK_ECHO) ? ack_dly[2] : 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_ph1 <= 2'b00;
    end else begin
      if (ph1_out == 2'b01 || ph1_out == 2'b11) illegal_ph1 <= illegal_ph1 + 1;
      if (ph1_out == 2'b10 && prev_ph1 != 2'b10) tokens.push_back(data_out);
      if (ph1_out == 2'b10 && prev_ph1 == 2'b10 && data_out !== prev_data)
        data_glitch <= data_glitch + 1;
      if (mem_rd_en) addrs.push_back(mem_addr);
      prev_ph1  <= ph1_out;
      prev_data <= data_out;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_tokens(input int n, input int budget);
    for (int i = 0; i < budget && tokens.size() < n; i++) tick();
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy !== 1'b0; i++) tick();
  endtask

  task automatic redirect(input logic [7:0] val);
    pc_load = 1'b1;
    pc_load_val = val;
    tick();
    pc_load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; pc_load = 1'b0; pc_load_val = '0; ack_mode = ACK_LOW;
    tick(3);
    n_cmp++; if (mem_rd_en !== 1'b0) begin n_bad++; $display("FAIL reset_rd_en: got %b want 0", mem_rd_en); end
    n_cmp++; if (mem_addr !== 8'h00) begin n_bad++; $display("FAIL reset_addr: got %h want 00", mem_addr); end
    n_cmp++; if (data_out !== 16'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0000", data_out); end
    n_cmp++; if (ph1_out !== 2'b00) begin n_bad++; $display("FAIL reset_ph1: got %b want 00", ph1_out); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    tick(4);
  endtask

  task automatic test_stream();
    logic [15:0] exp_w [4];
    logic [15:0] got;
    exp_w = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};
    ack_mode = ACK_ECHO;
    tokens.delete();
    run = 1'b1;
    wait_tokens(4, 400);
    run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      got = (i < tokens.size()) ? tokens[i] : 16'hDEAD;
      n_cmp++; if (got !== exp_w[i]) begin n_bad++; $display("FAIL stream_token%0d: got %h want %h", i, got, exp_w[i]); end
    end
    wait_idle(600);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stream_drain_busy: got %b want 0", busy); end
    n_cmp++; if (illegal_ph1 !== 0) begin n_bad++; $display("FAIL stream_ph1_code: got %0d illegal want 0", illegal_ph1); end
    n_cmp++; if (data_glitch !== 0) begin n_bad++; $display("FAIL stream_data_hold: got %0d changes want 0", data_glitch); end
  endtask

  task automatic test_stall();
    ack_mode = ACK_LOW;
    run = 1'b1;
    redirect(8'h00);
    addrs.delete();
    tokens.delete();
    tick(30);
    n_cmp++; if (addrs.size() !== 4) begin n_bad++; $display("FAIL stall_reads: got %0d want 4", addrs.size()); end
    n_cmp++; if (mem_rd_en !== 1'b0) begin n_bad++; $display("FAIL stall_rd_en: got %b want 0", mem_rd_en); end
    n_cmp++; if (ph1_out !== 2'b10) begin n_bad++; $display("FAIL stall_ph1: got %b want 10", ph1_out); end
    n_cmp++; if (data_out !== 16'hA001) begin n_bad++; $display("FAIL stall_data: got %h want A001", data_out); end
    n_cmp++; if (tokens.size() !== 1) begin n_bad++; $display("FAIL stall_tokens: got %0d want 1", tokens.size()); end
  endtask

  task automatic test_pc_load_req();
    logic [15:0] got;
    tokens.delete();
    redirect(8'h40);
    n_cmp++; if (ph1_out !== 2'b10) begin n_bad++; $display("FAIL pcl_req_ph1: got %b want 10", ph1_out); end
    n_cmp++; if (data_out !== 16'hA001) begin n_bad++; $display("FAIL pcl_req_data: got %h want A001", data_out); end
    ack_mode = ACK_ECHO;
    wait_tokens(2, 400);
    run = 1'b0;
    got = (tokens.size() > 0) ? tokens[0] : 16'hDEAD;
    n_cmp++; if (got !== 16'hC040) begin n_bad++; $display("FAIL pcl_req_next0: got %h want C040", got); end
    got = (tokens.size() > 1) ? tokens[1] : 16'hDEAD;
    n_cmp++; if (got !== 16'hC041) begin n_bad++; $display("FAIL pcl_req_next1: got %h want C041", got); end
    wait_idle(600);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL pcl_req_busy: got %b want 0", busy); end
  endtask

  task automatic test_wrap();
    logic [7:0]  exp_a [3];
    logic [7:0]  got_a;
    logic [15:0] got;
    exp_a = '{8'hFF, 8'h00, 8'h01};
    ack_mode = ACK_ECHO;
    run = 1'b1;
    redirect(8'hFF);
    addrs.delete();
    tokens.delete();
    wait_tokens(2, 400);
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      got_a = (i < addrs.size()) ? addrs[i] : 8'h5A;
      n_cmp++; if (got_a !== exp_a[i]) begin n_bad++; $display("FAIL wrap_addr%0d: got %h want %h", i, got_a, exp_a[i]); end
    end
    got = (tokens.size() > 0) ? tokens[0] : 16'hDEAD;
    n_cmp++; if (got !== 16'hC0FF) begin n_bad++; $display("FAIL wrap_token0: got %h want C0FF", got); end
    got = (tokens.size() > 1) ? tokens[1] : 16'hDEAD;
    n_cmp++; if (got !== 16'hA001) begin n_bad++; $display("FAIL wrap_token1: got %h want A001", got); end
    wait_idle(600);
  endtask

  task automatic test_reset_mid_req();
    logic [15:0] got;
    ack_mode = ACK_LOW;
    run = 1'b1;
    redirect(8'h00);
    tick(10);
    n_cmp++; if (ph1_out !== 2'b10) begin n_bad++; $display("FAIL rstreq_pre_ph1: got %b want 10", ph1_out); end
    rst = 1'b1; ack_mode = ACK_HIGH; run = 1'b0;
    tick();
    n_cmp++; if (ph1_out !== 2'b00) begin n_bad++; $display("FAIL rstreq_ph1: got %b want 00", ph1_out); end
    n_cmp++; if (data_out !== 16'h0) begin n_bad++; $display("FAIL rstreq_data: got %h want 0000", data_out); end
    rst = 1'b0;
    tick(3);
    tokens.delete();
    run = 1'b1;
    tick(15);
    n_cmp++; if (tokens.size() !== 0) begin n_bad++; $display("FAIL rstreq_stale_ack: got %0d tokens want 0", tokens.size()); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rstreq_busy: got %b want 1", busy); end
    ack_mode = ACK_ECHO;
    wait_tokens(1, 100);
    run = 1'b0;
    got = (tokens.size() > 0) ? tokens[0] : 16'hDEAD;
    n_cmp++; if (got !== 16'hA001) begin n_bad++; $display("FAIL rstreq_token: got %h want A001", got); end
    wait_idle(600);
  endtask

  task automatic test_pc_load_setup();
    bit seen = 1'b0;
    ack_mode = ACK_ECHO;
    run = 1'b0;
    redirect(8'h10);
    tokens.delete();
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (data_out === 16'hC010 && ph1_out === 2'b00) begin
        redirect(8'h20);
        seen = 1'b1;
      end else begin
        tick();
      end
    end
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL setup_reached: got %b want 1", seen); end
    tick(15);
    n_cmp++; if (tokens.size() !== 0) begin n_bad++; $display("FAIL setup_no_token: got %0d want 0", tokens.size()); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL setup_busy: got %b want 0", busy); end
    n_cmp++; if (data_out !== 16'h0) begin n_bad++; $display("FAIL setup_data: got %h want 0000", data_out); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {8'hC0, 8'(i)};
    mem[0] = 16'hA001; mem[1] = 16'hA002; mem[2] = 16'hA003; mem[3] = 16'hA004;
    test_reset();
    test_stream();
    test_stall();
    test_pc_load_req();
    test_wrap();
    test_reset_mid_req();
    test_pc_load_setup();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
